// File: rtl/mcs6530_bus_master_if.sv
// rtl/mcs6530_bus_master_if.sv - command/response channels and 6530 pin bundle for mcs6530_bus_master
interface mcs6530_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_region;
  logic       cmd_we;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] err_count;
  logic [9:0] A;
  logic [7:0] DI;
  logic       we_n;
  logic       RS0;
  logic       CS1;
  logic [7:0] DO;
  logic       OE;

  modport master (
    input  cmd_valid, cmd_region, cmd_we, cmd_addr, cmd_wdata, rsp_ready, DO, OE,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, err_count, A, DI, we_n, RS0, CS1
  );

  modport slave (
    output cmd_valid, cmd_region, cmd_we, cmd_addr, cmd_wdata, rsp_ready, DO, OE,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, err_count, A, DI, we_n, RS0, CS1
  );
endinterface

// File: rtl/mcs6530_bus_master.sv
// rtl/mcs6530_bus_master.sv - one-command-in-flight bus initiator for a single mcs6530
// Optional read timeout/re-sample in WAIT is enabled by defining MCS_MASTER_TIMEOUT_EN.
module mcs6530_bus_master #(
  parameter int TIMEOUT_CYCLES = 4
) (
  input logic                 phi2,
  input logic                 rst,
  mcs6530_bus_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..15");
  end

  state_t     state, state_next;
  logic [9:0] a_q, a_d;
  logic [7:0] di_q, di_d;
  logic       we_n_q, we_n_d;
  logic       rs0_q, rs0_d;
  logic       cs1_q, cs1_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rerr_q, rerr_d;
  logic [7:0] errc_q, errc_d;
  logic       leave_wait;
`ifdef MCS_MASTER_TIMEOUT_EN
  logic [3:0] wcnt_q, wcnt_d;
`endif

  always_ff @(posedge phi2) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= 10'h000;
      di_q    <= 8'h00;
      we_n_q  <= 1'b1;
      rs0_q   <= 1'b1;
      cs1_q   <= 1'b0;
      rdata_q <= 8'h00;
      rerr_q  <= 1'b0;
      errc_q  <= 8'h00;
`ifdef MCS_MASTER_TIMEOUT_EN
      wcnt_q  <= 4'd0;
`endif
    end else begin
      state   <= state_next;
      a_q     <= a_d;
      di_q    <= di_d;
      we_n_q  <= we_n_d;
      rs0_q   <= rs0_d;
      cs1_q   <= cs1_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      errc_q  <= errc_d;
`ifdef MCS_MASTER_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  always_comb begin
    state_next = state;
    a_d        = a_q;
    di_d       = di_q;
    we_n_d     = we_n_q;
    rs0_d      = rs0_q;
    cs1_d      = cs1_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    errc_d     = errc_q;
    leave_wait = 1'b0;
`ifdef MCS_MASTER_TIMEOUT_EN
    wcnt_d     = wcnt_q;
`endif
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (!bus.cmd_region[1]) begin
            state_next = DRIVE;
            a_d        = bus.cmd_addr;
            di_d       = bus.cmd_wdata;
            we_n_d     = !bus.cmd_we;
            rs0_d      = bus.cmd_region[0];
            cs1_d      = !bus.cmd_region[0];
          end else begin
            // Reserved regions answer immediately and never touch the bus.
            state_next = RESP;
            rdata_d    = 8'h00;
            rerr_d     = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_next = WAIT;
`ifdef MCS_MASTER_TIMEOUT_EN
        wcnt_d     = 4'd0;
`endif
      end
      WAIT: begin
        if (!we_n_q) begin
          leave_wait = 1'b1;
          rdata_d    = 8'h00;
          rerr_d     = 1'b0;
        end else begin
`ifdef MCS_MASTER_TIMEOUT_EN
          if (bus.OE) begin
            leave_wait = 1'b1;
            rdata_d    = bus.DO;
            rerr_d     = 1'b0;
          end else if (wcnt_q == 4'(TIMEOUT_CYCLES)) begin
            leave_wait = 1'b1;
            rdata_d    = 8'h00;
            rerr_d     = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
`else
          leave_wait = 1'b1;
          rdata_d    = bus.OE ? bus.DO : 8'h00;
          rerr_d     = !bus.OE;
`endif
        end
        if (leave_wait) begin
          state_next = RESP;
          a_d        = 10'h000;
          di_d       = 8'h00;
          we_n_d     = 1'b1;
          rs0_d      = 1'b1;
          cs1_d      = 1'b0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
          if (rerr_q && (errc_q != 8'hFF)) begin
            errc_d = errc_q + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.err_count = errc_q;
  assign bus.A         = a_q;
  assign bus.DI        = di_q;
  assign bus.we_n      = we_n_q;
  assign bus.RS0       = rs0_q;
  assign bus.CS1       = cs1_q;
endmodule

// File: tb/tb_mcs6530_bus_master.sv
// tb/tb_mcs6530_bus_master.sv - scoreboard bench for mcs6530_bus_master with a behavioural 6530 model
module tb_mcs6530_bus_master;
  logic phi2 = 1'b0;
  logic rst  = 1'b1;
  int   cyc  = 0;

  always #5 phi2 = ~phi2;
  always @(posedge phi2) cyc <= cyc + 1;

  mcs6530_bus_master_if bus ();

  mcs6530_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .phi2 (phi2),
    .rst  (rst),
    .bus  (bus)
  );

`ifdef MCS_MASTER_TIMEOUT_EN
  localparam int UNMAP_LAT = 7;
`else
  localparam int UNMAP_LAT = 3;
`endif

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         hs;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_rsp   = 0;
  int   n_unexp = 0;
  int   first_cyc = 0;
  bit   in_rsp  = 0;
  int   model_errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [9:0] a);
    return a[7:0] ^ {6'b0, a[9:8]} ^ 8'h3C;
  endfunction

  // Behavioural 6530: ROM when RS0=0/CS1=1, 64-byte RAM at 0x3C0..0x3FF when RS0=1/CS1=0.
  logic [7:0] ram [64];
  always_comb begin
    bus.OE = 1'b0;
    bus.DO = 8'hEE;
    if (!bus.RS0 && bus.CS1) begin
      bus.OE = 1'b1;
      bus.DO = rom_byte(bus.A);
    end else if (bus.RS0 && !bus.CS1 && bus.we_n && (bus.A >= 10'h3C0)) begin
      bus.OE = 1'b1;
      bus.DO = ram[bus.A[5:0]];
    end
  end
  always @(posedge phi2) begin
    if (bus.RS0 && !bus.CS1 && !bus.we_n && (bus.A >= 10'h3C0)) ram[bus.A[5:0]] <= bus.DI;
  end

  always @(negedge phi2) begin
    if (rst) begin
      in_rsp = 0;
    end else if (bus.rsp_valid) begin
      if (!in_rsp) begin
        in_rsp    = 1;
        first_cyc = cyc;
      end
      if (bus.rsp_ready) begin
        in_rsp = 0;
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_unexp++;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(first_cyc - e.hs), 32'(e.lat));
          if (e.err && model_errs < 255) model_errs++;
        end
      end
    end
  end

  task automatic send(input logic [1:0] rg, input logic we, input logic [9:0] ad, input logic [7:0] wd,
                      input logic [7:0] ed, input logic ee, input int el, input bit push);
    int   n;
    exp_t e;
    @(posedge phi2); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_region = rg;
    bus.cmd_we     = we;
    bus.cmd_addr   = ad;
    bus.cmd_wdata  = wd;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge phi2); #1;
      n++;
    end
    chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    if (push) begin
      e.data = ed; e.err = ee; e.lat = el; e.hs = cyc;
      exp_q.push_back(e);
      n_push++;
    end
    @(posedge phi2); #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_region = 2'($urandom);
    bus.cmd_we     = 1'($urandom);
    bus.cmd_addr   = 10'($urandom);
    bus.cmd_wdata  = 8'($urandom);
    chk("drv_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("drv_A", 32'(bus.A), rg[1] ? 32'd0 : 32'(ad));
    chk("drv_DI", 32'(bus.DI), rg[1] ? 32'd0 : 32'(wd));
    chk("drv_we_n", 32'(bus.we_n), rg[1] ? 32'd1 : 32'(!we));
    chk("drv_RS0", 32'(bus.RS0), rg[1] ? 32'd1 : 32'(rg == 2'd1));
    chk("drv_CS1", 32'(bus.CS1), rg[1] ? 32'd0 : 32'(rg == 2'd0));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge phi2); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_A"}, 32'(bus.A), 32'd0);
    chk({tag, "_DI"}, 32'(bus.DI), 32'd0);
    chk({tag, "_we_n"}, 32'(bus.we_n), 32'd1);
    chk({tag, "_RS0"}, 32'(bus.RS0), 32'd1);
    chk({tag, "_CS1"}, 32'(bus.CS1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] ad;
    logic [7:0] wd;
    int         n;
    bus.cmd_valid  = 1'b0;
    bus.cmd_region = 2'd0;
    bus.cmd_we     = 1'b0;
    bus.cmd_addr   = 10'h000;
    bus.cmd_wdata  = 8'h00;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge phi2);
    #1;
    rst = 1'b0;

    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk_idle("rst");

    send(2'd0, 1'b0, 10'h3FF, 8'h00, rom_byte(10'h3FF), 1'b0, 3, 1);
    send(2'd1, 1'b1, 10'h3C5, 8'hA5, 8'h00, 1'b0, 3, 1);
    send(2'd1, 1'b0, 10'h3C5, 8'h00, 8'hA5, 1'b0, 3, 1);
    for (int i = 0; i < 4; i++) begin
      ad = 10'($urandom);
      send(2'd0, 1'b0, ad, 8'($urandom), rom_byte(ad), 1'b0, 3, 1);
      ad = 10'h3C0 | 10'($urandom_range(0, 63));
      wd = 8'($urandom);
      send(2'd1, 1'b1, ad, wd, 8'h00, 1'b0, 3, 1);
      send(2'd1, 1'b0, ad, 8'h00, wd, 1'b0, 3, 1);
    end
    wait_done();
    chk("err_count_clean", 32'(bus.err_count), 32'd0);

    send(2'd1, 1'b0, 10'h000, 8'h00, 8'h00, 1'b1, UNMAP_LAT, 1);
    wait_done();
    chk("err_count_unmapped", 32'(bus.err_count), 32'd1);
    send(2'd1, 1'b1, 10'h000, 8'h77, 8'h00, 1'b0, 3, 1);
    send(2'd2, 1'b0, 10'h2AB, 8'h00, 8'h00, 1'b1, 1, 1);
    send(2'd3, 1'b1, 10'h155, 8'h5A, 8'h00, 1'b1, 1, 1);
    wait_done();
    chk("err_count_reserved", 32'(bus.err_count), 32'd3);
    chk_idle("after_reserved");

    // Backpressure: five stalled response cycles, handshake on the sixth.
    bus.rsp_ready = 1'b0;
    send(2'd0, 1'b0, 10'h155, 8'h00, rom_byte(10'h155), 1'b0, 3, 1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge phi2); #1;
      n++;
    end
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.rsp_data), 32'(rom_byte(10'h155)));
      chk("bp_hold_err", 32'(bus.rsp_err), 32'd0);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge phi2); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge phi2); #1;
    chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_after_ready", 32'(bus.cmd_ready), 32'd1);
    wait_done();

    for (int i = 0; i < 252; i++) begin
      send(2'd2 | 2'(i & 1), 1'b0, 10'($urandom), 8'h00, 8'h00, 1'b1, 1, 1);
    end
    wait_done();
    chk("err_count_255", 32'(bus.err_count), 32'hFF);
    chk("err_count_model", 32'(bus.err_count), 32'(model_errs));
    send(2'd1, 1'b0, 10'h001, 8'h00, 8'h00, 1'b1, UNMAP_LAT, 1);
    wait_done();
    chk("err_count_sat", 32'(bus.err_count), 32'hFF);

    // Reset during WAIT of a read: the response must never appear.
    send(2'd0, 1'b0, 10'h0AA, 8'h00, 8'h00, 1'b0, 3, 0);
    @(posedge phi2); #1;
    rst = 1'b1;
    @(posedge phi2); #1;
    rst = 1'b0;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_err_count", 32'(bus.err_count), 32'd0);
    chk_idle("mid_rst");
    model_errs = 0;
    repeat (10) @(posedge phi2);
    #1;
    chk("mid_rst_no_rsp", 32'(n_rsp), 32'(n_push));

    send(2'd0, 1'b0, 10'h2C3, 8'h00, rom_byte(10'h2C3), 1'b0, 3, 1);
    wait_done();
    chk("post_rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rsp_total", 32'(n_rsp), 32'(n_push));
    chk("rsp_unexpected", 32'(n_unexp), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
